// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Shared constants for the UART receive datapath.
//   - Parity mode selectors (PARITY parameter values).
//   - Receiver FSM state encodings.
// ----------------------------------------------------------------------------
package uart_pkg;

   // Parity mode selectors
   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_EVEN = 1;
   localparam int unsigned PAR_ODD  = 2;

   // Receiver FSM states. The S_ prefix keeps S_PARITY distinct from the
   // PARITY parameter of the receiver.
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

endpackage : uart_pkg

// File: rtl/rx_sync_filter.sv
// ----------------------------------------------------------------------------
// rx_sync_filter
//   Brings the raw serial line into the CLK domain and removes short glitches.
//   Two flops synchronise the line, then a 2-of-3 majority vote over the
//   synchronised value and its two previous samples produces the output.
//   Latency from a line edge to an output edge is 4 CLK cycles. Pulses
//   shorter than 2 cycles are suppressed. Everything resets to 1 (idle line).
//
//   Ports:
//     CLK       in   system clock
//     CLR       in   asynchronous active-high reset
//     Serial_i  in   raw serial line
//     Filt_o    out  synchronised, majority-filtered line
// ----------------------------------------------------------------------------
module rx_sync_filter (
   input  logic CLK,
   input  logic CLR,
   input  logic Serial_i,
   output logic Filt_o
);

   logic meta_q;
   logic sync_q;
   logic hist1_q;
   logic hist2_q;
   logic filt_q;

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         meta_q  <= 1'b1;
         sync_q  <= 1'b1;
         hist1_q <= 1'b1;
         hist2_q <= 1'b1;
         filt_q  <= 1'b1;
      end else begin
         meta_q  <= Serial_i;
         sync_q  <= meta_q;
         hist1_q <= sync_q;
         hist2_q <= hist1_q;
         filt_q  <= (sync_q & hist1_q) | (sync_q & hist2_q) | (hist1_q & hist2_q);
      end
   end

   assign Filt_o = filt_q;

endmodule : rx_sync_filter

// File: rtl/uart_rx_param.sv
// ----------------------------------------------------------------------------
// uart_rx_param
//   Parametrised UART receiver with an internal oversampling tick generator,
//   configurable data width, parity mode and stop-bit count, and a
//   valid/ack output handshake with sticky overrun detection.
//
//   Ports:
//     CLK           in   system clock
//     CLR           in   asynchronous active-high reset
//     Baud_Div      in   CLK cycles per oversample tick minus 1
//     Serial_input  in   raw serial line, idle high
//     Data          out  received word, LSB first on the line
//     Data_Valid    out  Data and error flags are held and valid
//     Data_Ack      in   consumer has taken Data (used while Data_Valid=1)
//     Parity_ERR    out  parity mismatch on the held word
//     Frame_ERR     out  a stop bit of the held word was sampled low
//     Overrun_ERR   out  sticky: frame completed while previous word unacked
//     Busy          out  receiver is inside a frame
// ----------------------------------------------------------------------------
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = 1,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned DIV_W      = 16
) (
   input  logic                 CLK,
   input  logic                 CLR,
   input  logic [DIV_W-1:0]     Baud_Div,
   input  logic                 Serial_input,
   output logic [DATA_BITS-1:0] Data,
   output logic                 Data_Valid,
   input  logic                 Data_Ack,
   output logic                 Parity_ERR,
   output logic                 Frame_ERR,
   output logic                 Overrun_ERR,
   output logic                 Busy
);

   localparam int unsigned SW = $clog2(OVERSAMPLE);
   localparam int unsigned BW = $clog2(DATA_BITS);
   localparam logic [SW-1:0] SAMP_MID  = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
   localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
   localparam logic          ODD_PAR   = (PARITY == PAR_ODD);

   // Filtered line and falling-edge detect
   logic filt;
   logic line_prev_q;
   logic fall;

   rx_sync_filter u_sync (
      .CLK      (CLK),
      .CLR      (CLR),
      .Serial_i (Serial_input),
      .Filt_o   (filt)
   );

   assign fall = line_prev_q & ~filt;

   // Frame state
   logic [2:0]           state_q,   state_d;
   logic [DIV_W-1:0]     cnt_q,     cnt_d;
   logic [DIV_W-1:0]     div_q,     div_d;
   logic [SW-1:0]        samp_q,    samp_d;
   logic [BW-1:0]        bitc_q,    bitc_d;
   logic                 stopc_q,   stopc_d;
   logic [DATA_BITS-1:0] shift_q,   shift_d;
   logic                 pacc_q,    pacc_d;
   logic                 facc_q,    facc_d;

   // Output registers
   logic [DATA_BITS-1:0] data_q,    data_d;
   logic                 valid_q,   valid_d;
   logic                 perr_q,    perr_d;
   logic                 ferr_q,    ferr_d;
   logic                 oerr_q,    oerr_d;

   logic tick;
   logic commit;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      samp_d  = samp_q;
      bitc_d  = bitc_q;
      stopc_d = stopc_q;
      shift_d = shift_q;
      pacc_d  = pacc_q;
      facc_d  = facc_q;
      data_d  = data_q;
      valid_d = valid_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      oerr_d  = oerr_q;
      tick    = 1'b0;
      commit  = 1'b0;

      // Tick generator: divisor latched when leaving IDLE so mid-frame
      // changes to Baud_Div do not disturb the bit timing.
      if (state_q == S_IDLE) begin
         if (fall) begin
            state_d = S_START;
            cnt_d   = Baud_Div;
            div_d   = Baud_Div;
            samp_d  = '0;
            bitc_d  = '0;
            stopc_d = 1'b0;
            pacc_d  = 1'b0;
            facc_d  = 1'b0;
         end
      end else begin
         tick  = (cnt_q == '0);
         cnt_d = tick ? div_q : (cnt_q - DIV_W'(1));
      end

      if (tick) begin
         unique case (state_q)
            S_START: begin
               if (samp_q == SAMP_MID) begin
                  samp_d  = '0;
                  state_d = filt ? S_IDLE : S_DATA;
               end else begin
                  samp_d = samp_q + SW'(1);
               end
            end
            S_DATA: begin
               if (samp_q == SAMP_LAST) begin
                  samp_d  = '0;
                  shift_d = {filt, shift_q[DATA_BITS-1:1]};
                  if (bitc_q == BIT_LAST) begin
                     state_d = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                  end else begin
                     bitc_d = bitc_q + BW'(1);
                  end
               end else begin
                  samp_d = samp_q + SW'(1);
               end
            end
            S_PARITY: begin
               if (samp_q == SAMP_LAST) begin
                  samp_d  = '0;
                  pacc_d  = ((^shift_q) ^ filt) != ODD_PAR;
                  state_d = S_STOP;
               end else begin
                  samp_d = samp_q + SW'(1);
               end
            end
            S_STOP: begin
               if (samp_q == SAMP_LAST) begin
                  samp_d = '0;
                  facc_d = facc_q | ~filt;
                  if (stopc_q == STOP_LAST) begin
                     commit  = 1'b1;
                     state_d = S_IDLE;
                  end else begin
                     stopc_d = 1'b1;
                  end
               end else begin
                  samp_d = samp_q + SW'(1);
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      // Output handshake: a commit into a free (or simultaneously acked)
      // holding register loads it; otherwise the new word is dropped.
      if (commit) begin
         if (!valid_q || Data_Ack) begin
            data_d  = shift_q;
            perr_d  = pacc_q;
            ferr_d  = facc_d;
            oerr_d  = 1'b0;
            valid_d = 1'b1;
         end else begin
            oerr_d = 1'b1;
         end
      end else if (valid_q && Data_Ack) begin
         valid_d = 1'b0;
         perr_d  = 1'b0;
         ferr_d  = 1'b0;
         oerr_d  = 1'b0;
      end
   end

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         line_prev_q <= 1'b1;
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         div_q       <= '0;
         samp_q      <= '0;
         bitc_q      <= '0;
         stopc_q     <= 1'b0;
         shift_q     <= '0;
         pacc_q      <= 1'b0;
         facc_q      <= 1'b0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         perr_q      <= 1'b0;
         ferr_q      <= 1'b0;
         oerr_q      <= 1'b0;
      end else begin
         line_prev_q <= filt;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         div_q       <= div_d;
         samp_q      <= samp_d;
         bitc_q      <= bitc_d;
         stopc_q     <= stopc_d;
         shift_q     <= shift_d;
         pacc_q      <= pacc_d;
         facc_q      <= facc_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         perr_q      <= perr_d;
         ferr_q      <= ferr_d;
         oerr_q      <= oerr_d;
      end
   end

   assign Data        = data_q;
   assign Data_Valid  = valid_q;
   assign Parity_ERR  = perr_q;
   assign Frame_ERR   = ferr_q;
   assign Overrun_ERR = oerr_q;
   assign Busy        = (state_q != S_IDLE);

endmodule : uart_rx_param

// File: tb/tb_uart_rx_param.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_param
//   Directed bench for uart_rx_param with Baud_Div=3, OVERSAMPLE=16
//   (64 CLK per bit), 8 data bits, even parity, 1 stop bit.
// ----------------------------------------------------------------------------
module tb_uart_rx_param;

   localparam int BIT_CYC = 64;

   logic        CLK = 1'b0;
   logic        CLR = 1'b1;
   logic [15:0] Baud_Div = 16'd3;
   logic        Serial_input = 1'b1;
   logic [7:0]  Data;
   logic        Data_Valid;
   logic        Data_Ack = 1'b0;
   logic        Parity_ERR;
   logic        Frame_ERR;
   logic        Overrun_ERR;
   logic        Busy;

   int total = 0;
   int bad   = 0;

   uart_rx_param #(
      .DATA_BITS  (8),
      .PARITY     (1),
      .STOP_BITS  (1),
      .OVERSAMPLE (16),
      .DIV_W      (16)
   ) dut (
      .CLK          (CLK),
      .CLR          (CLR),
      .Baud_Div     (Baud_Div),
      .Serial_input (Serial_input),
      .Data         (Data),
      .Data_Valid   (Data_Valid),
      .Data_Ack     (Data_Ack),
      .Parity_ERR   (Parity_ERR),
      .Frame_ERR    (Frame_ERR),
      .Overrun_ERR  (Overrun_ERR),
      .Busy         (Busy)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      Serial_input = 1'b1;
      repeat (n) @(negedge CLK);
   endtask

   // start bit, 8 data bits LSB first, parity bit, stop bit
   task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
      logic [10:0] bits;
      bits = {stp, par, d, 1'b0};
      for (int i = 0; i < 11; i++) begin
         Serial_input = bits[i];
         repeat (BIT_CYC) @(negedge CLK);
      end
      Serial_input = 1'b1;
      repeat (20) @(negedge CLK);
   endtask

   task automatic ack_word();
      Data_Ack = 1'b1;
      @(negedge CLK);
      Data_Ack = 1'b0;
   endtask

   initial begin
      int busy_seen;

      // Reset state
      repeat (3) @(negedge CLK);
      check("rst_data",  32'(Data), 32'h00);
      check("rst_valid", 32'(Data_Valid), 32'd0);
      check("rst_perr",  32'(Parity_ERR), 32'd0);
      check("rst_ferr",  32'(Frame_ERR), 32'd0);
      check("rst_oerr",  32'(Overrun_ERR), 32'd0);
      check("rst_busy",  32'(Busy), 32'd0);
      CLR = 1'b0;
      idle(10);

      // Clean frame 0xA5, even parity bit 0
      send_frame(8'hA5, 1'b0, 1'b1);
      check("a5_data",  32'(Data), 32'hA5);
      check("a5_valid", 32'(Data_Valid), 32'd1);
      check("a5_perr",  32'(Parity_ERR), 32'd0);
      check("a5_ferr",  32'(Frame_ERR), 32'd0);
      check("a5_oerr",  32'(Overrun_ERR), 32'd0);
      check("a5_busy",  32'(Busy), 32'd0);
      ack_word();
      check("a5_ack_valid", 32'(Data_Valid), 32'd0);
      check("a5_ack_data",  32'(Data), 32'hA5);

      // Parity error
      send_frame(8'hA5, 1'b1, 1'b1);
      check("perr_data",  32'(Data), 32'hA5);
      check("perr_valid", 32'(Data_Valid), 32'd1);
      check("perr_perr",  32'(Parity_ERR), 32'd1);
      check("perr_ferr",  32'(Frame_ERR), 32'd0);
      ack_word();
      check("perr_ack_perr", 32'(Parity_ERR), 32'd0);

      // Framing error, then a good frame
      send_frame(8'h3C, 1'b0, 1'b0);
      check("ferr_data",  32'(Data), 32'h3C);
      check("ferr_ferr",  32'(Frame_ERR), 32'd1);
      check("ferr_perr",  32'(Parity_ERR), 32'd0);
      ack_word();
      check("ferr_ack_ferr", 32'(Frame_ERR), 32'd0);
      idle(30);
      send_frame(8'h55, 1'b0, 1'b1);
      check("after_ferr_data",  32'(Data), 32'h55);
      check("after_ferr_valid", 32'(Data_Valid), 32'd1);
      check("after_ferr_ferr",  32'(Frame_ERR), 32'd0);
      check("after_ferr_perr",  32'(Parity_ERR), 32'd0);
      ack_word();
      idle(10);

      // 1-cycle glitch must never reach the FSM
      busy_seen = 0;
      Serial_input = 1'b0;
      @(negedge CLK);
      Serial_input = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (Busy) busy_seen = 1;
         @(negedge CLK);
      end
      check("glitch_busy", 32'(busy_seen), 32'd0);

      // 20-cycle low pulse: starts a frame, rejected at the mid-start sample
      busy_seen = 0;
      Serial_input = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (i == 20) Serial_input = 1'b1;
         if (Busy) busy_seen = 1;
         @(negedge CLK);
      end
      check("short_busy_seen", 32'(busy_seen), 32'd1);
      check("short_busy_end",  32'(Busy), 32'd0);
      check("short_valid",     32'(Data_Valid), 32'd0);
      check("short_data",      32'(Data), 32'h55);

      // Overrun: two frames without acknowledge
      send_frame(8'h3C, 1'b0, 1'b1);
      check("ovr_first_valid", 32'(Data_Valid), 32'd1);
      check("ovr_first_oerr",  32'(Overrun_ERR), 32'd0);
      send_frame(8'hC3, 1'b0, 1'b1);
      check("ovr_data",  32'(Data), 32'h3C);
      check("ovr_valid", 32'(Data_Valid), 32'd1);
      check("ovr_oerr",  32'(Overrun_ERR), 32'd1);
      ack_word();
      check("ovr_ack_valid", 32'(Data_Valid), 32'd0);
      check("ovr_ack_oerr",  32'(Overrun_ERR), 32'd0);
      check("ovr_ack_perr",  32'(Parity_ERR), 32'd0);
      check("ovr_ack_ferr",  32'(Frame_ERR), 32'd0);
      idle(10);

      // CLR mid-frame: start bit plus three data bits of 0x81, then reset
      Serial_input = 1'b0;
      repeat (BIT_CYC) @(negedge CLK);
      Serial_input = 1'b1;
      repeat (BIT_CYC) @(negedge CLK);
      Serial_input = 1'b0;
      repeat (2 * BIT_CYC) @(negedge CLK);
      check("mid_busy_before_clr", 32'(Busy), 32'd1);
      CLR = 1'b1;
      #1;
      check("clr_data",  32'(Data), 32'h00);
      check("clr_valid", 32'(Data_Valid), 32'd0);
      check("clr_busy",  32'(Busy), 32'd0);
      check("clr_oerr",  32'(Overrun_ERR), 32'd0);
      @(negedge CLK);
      Serial_input = 1'b1;
      CLR = 1'b0;
      idle(20);
      check("post_clr_busy", 32'(Busy), 32'd0);
      send_frame(8'h55, 1'b0, 1'b1);
      check("post_clr_data",  32'(Data), 32'h55);
      check("post_clr_valid", 32'(Data_Valid), 32'd1);
      check("post_clr_perr",  32'(Parity_ERR), 32'd0);
      check("post_clr_ferr",  32'(Frame_ERR), 32'd0);
      check("post_clr_oerr",  32'(Overrun_ERR), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_uart_rx_param
